// File: rtl/echo_ranging_ctrl_pkg.sv
// Shared state encodings and the default 6 MHz timing constants for the echo ranging controller.
package echo_ranging_ctrl_pkg;

    localparam int DEF_TRIG_CYCLES         = 60;
    localparam int DEF_ECHO_TIMEOUT_CYCLES = 228000;
    localparam int DEF_PERIOD_CYCLES       = 360000;
    localparam int DEF_CNT_W               = 19;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    // The repeat period must outlast trigger plus timeout and fit in the counter width.
    function automatic bit params_legal(input int trig, input int timeout,
                                        input int period, input int cnt_w);
        return (period > trig + timeout) && (period < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/echo_ranging_ctrl_if.sv
// Request/result bundle between the ranging controller and its environment.
interface echo_ranging_ctrl_if
    import echo_ranging_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             start;
    logic             auto_en;
    logic             echo;
    logic             trig;
    logic             busy;
    logic             dist_valid;
    logic [CNT_W-1:0] echo_cycles;
    logic             timeout;

    modport master (
        output start, auto_en, echo,
        input  trig, busy, dist_valid, echo_cycles, timeout
    );

    modport slave (
        input  start, auto_en, echo,
        output trig, busy, dist_valid, echo_cycles, timeout
    );

endinterface

// File: rtl/echo_ranging_ctrl_echo_sync.sv
// Brings the asynchronous echo pin into the clk domain and flags its edges.
module echo_sync
    import echo_ranging_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic echo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            echo_s <= 1'b0;
            echo_q <= 1'b0;
        end else begin
            meta   <= echo;
            echo_s <= meta;
            echo_q <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_q;
    assign fall = ~echo_s & echo_q;

endmodule

// File: rtl/echo_ranging_ctrl.sv
// Ultrasonic ranging sequencer: trigger pulse, echo width measurement, timeout and repeat-period holdoff.
module echo_ranging_ctrl
    import echo_ranging_ctrl_pkg::*;
#(
    parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
    parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
    parameter int PERIOD_CYCLES       = DEF_PERIOD_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input logic                clk,
    input logic                rst,
    echo_ranging_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    state_t           state;
    logic             trig_r;
    logic             busy_r;
    logic             dist_valid_r;
    logic             timeout_r;
    logic [CNT_W-1:0] echo_cycles_r;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] meas_cnt;

    logic echo_s;
    logic rise;
    logic fall;

    echo_sync u_echo_sync (
        .clk    (clk),
        .rst    (rst),
        .echo   (bus.echo),
        .echo_s (echo_s),
        .rise   (rise),
        .fall   (fall)
    );

    // period_cnt runs from the trigger rise through holdoff, so it also times the trigger width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            trig_r        <= 1'b0;
            busy_r        <= 1'b0;
            dist_valid_r  <= 1'b0;
            timeout_r     <= 1'b0;
            echo_cycles_r <= '0;
            period_cnt    <= '0;
            to_cnt        <= '0;
            meas_cnt      <= '0;
        end else begin
            dist_valid_r <= 1'b0;
            timeout_r    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    period_cnt <= '0;
                    if (bus.start || bus.auto_en) begin
                        state  <= ST_TRIG;
                        trig_r <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                ST_TRIG: begin
                    period_cnt <= period_cnt + CNT_ONE;
                    if (period_cnt == TRIG_LAST) begin
                        state  <= ST_WAIT_RISE;
                        trig_r <= 1'b0;
                        to_cnt <= '0;
                    end
                end
                ST_WAIT_RISE: begin
                    period_cnt <= period_cnt + CNT_ONE;
                    to_cnt     <= to_cnt + CNT_ONE;
                    if (rise) begin
                        state    <= ST_MEASURE;
                        meas_cnt <= CNT_ONE;
                    end else if (to_cnt >= TIMEOUT_LAST) begin
                        state     <= ST_HOLDOFF;
                        timeout_r <= 1'b1;
                    end
                end
                // A fall on the final timeout cycle still counts as a valid measurement.
                ST_MEASURE: begin
                    period_cnt <= period_cnt + CNT_ONE;
                    to_cnt     <= to_cnt + CNT_ONE;
                    if (fall) begin
                        state         <= ST_HOLDOFF;
                        echo_cycles_r <= meas_cnt;
                        dist_valid_r  <= 1'b1;
                    end else if (to_cnt >= TIMEOUT_LAST) begin
                        state     <= ST_HOLDOFF;
                        timeout_r <= 1'b1;
                    end else if (echo_s) begin
                        meas_cnt <= meas_cnt + CNT_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    period_cnt <= period_cnt + CNT_ONE;
                    if (period_cnt == PERIOD_LAST) begin
                        if (bus.auto_en) begin
                            state      <= ST_TRIG;
                            trig_r     <= 1'b1;
                            period_cnt <= '0;
                        end else begin
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    trig_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig        = trig_r;
    assign bus.busy        = busy_r;
    assign bus.dist_valid  = dist_valid_r;
    assign bus.timeout     = timeout_r;
    assign bus.echo_cycles = echo_cycles_r;

    param_legal_a: assert property (@(posedge clk) disable iff (rst)
        params_legal(TRIG_CYCLES, ECHO_TIMEOUT_CYCLES, PERIOD_CYCLES, CNT_W));

endmodule
